// File: rtl/seq_div_datapath.sv
// rtl/seq_div_datapath.sv - multi-cycle signed divider, restoring, one quotient bit per cycle
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request, sampled when not busy (IDLE or DONE)
//   dividend_i        signed dividend, sampled with start
//   divisor_i         signed divisor, sampled with start
//   quotient_o        signed truncating quotient, valid while done
//   remainder_o       signed remainder (sign of dividend), valid while done
//   busy              operation in flight (RUN/FIX)
//   done              result valid, held until the next accepted start
//   div_by_zero_o     divisor was zero
//   overflow_o        most-negative dividend divided by -1
`timescale 1ns/1ps

module seq_div_datapath #(
   parameter  int WIDTH     = 16,
   localparam int DIVCYCLES = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero_o,
   output logic             overflow_o
);

   // Counter only has to reach WIDTH-1; sizing from DIVCYCLES keeps headroom.
   localparam int CNT_W = $clog2(DIVCYCLES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     rem_q, rem_d;          // partial remainder
   logic [WIDTH-1:0]   quo_q, quo_d;          // dividend magnitude shifts out, quotient bits shift in
   logic [WIDTH-1:0]   dvs_q, dvs_d;          // divisor magnitude
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_pend_q, dbz_pend_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH+1:0]   shifted;
   logic [WIDTH+1:0]   trial;
   logic [WIDTH-1:0]   abs_dividend;
   logic [WIDTH-1:0]   abs_divisor;
   logic [WIDTH-1:0]   min_neg;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      dbz_pend_d  = dbz_pend_q;
      ovf_pend_d  = ovf_pend_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = done_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;

      min_neg      = {1'b1, {(WIDTH-1){1'b0}}};
      // Negating the most-negative value wraps back to 2^(WIDTH-1), which is
      // exactly the unsigned magnitude we want.
      abs_dividend = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
      abs_divisor  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;

      // Top bit of trial is the borrow: set means the divisor did not fit.
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {2'b00, dvs_q};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               neg_quo_d  = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
               neg_rem_d  = dividend_i[WIDTH-1];
               quo_d      = abs_dividend;
               dvs_d      = abs_divisor;
               rem_d      = '0;
               cnt_d      = '0;
               dbz_pend_d = (divisor_i == '0);
               ovf_pend_d = (dividend_i == min_neg) && (divisor_i == '1);
               done_d     = 1'b0;
               dbz_d      = 1'b0;
               ovf_d      = 1'b0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (!trial[WIDTH+1]) begin
               rem_d = trial[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            // With a zero divisor every trial succeeds, so the partial remainder
            // ends up holding |dividend| and the sign fix restores the dividend.
            if (dbz_pend_q) begin
               quotient_d = '1;
            end else begin
               quotient_d = neg_quo_q ? -quo_q : quo_q;
            end
            remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            dbz_d       = dbz_pend_q;
            ovf_d       = ovf_pend_q;
            done_d      = 1'b1;
            state_d     = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         dbz_pend_q  <= 1'b0;
         ovf_pend_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         dbz_pend_q  <= dbz_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign busy          = (state_q == S_RUN) || (state_q == S_FIX);
   assign done          = done_q;
   assign div_by_zero_o = dbz_q;
   assign overflow_o    = ovf_q;

endmodule
